// File: rtl/imem_loader.sv
// Instruction store (256x8) with a valid/ready boot loader that holds the CPU in reset until an image is loaded.
// Optional trailing-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inData,
  input  logic       inValid,
  output logic       inReady,
  input  logic       reload,
  input  logic [7:0] instAddress,
  output logic [7:0] instruction,
  output logic       cpuRst,
  output logic       loadDone,
  output logic       loadError,
  output logic [8:0] loadCount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd2,
`endif
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  // Handshake: a byte transfers on a rising edge when inValid && inReady.
  // inReady is decoded from state, rst and reload only, never from inValid.
  state_t     state;
  state_t     stateNext;
  logic       rstSeen;
  logic       readyState;
  logic       accept;
  logic [8:0] loadLen;
  logic [8:0] count;
  logic [8:0] countNext;
  logic [7:0] mem [256];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign countNext = count + 9'd1;
  assign loadCount = count;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign readyState = (state == IDLE) || (state == LOAD) || (state == CHECK);
  assign loadError  = rst && (state == ERROR);
`else
  assign readyState = (state == IDLE) || (state == LOAD);
  assign loadError  = 1'b0;
`endif

  // rstSeen keeps inReady low until one edge has been sampled out of reset.
  assign inReady  = rst && rstSeen && !reload && readyState;
  assign accept   = inValid && inReady;
  assign cpuRst   = rst && (state == RUN);
  assign loadDone = rst && (state == RUN);

  assign instruction = mem[instAddress];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) stateNext = LOAD;
      end
      LOAD: begin
        if (accept && (countNext == loadLen)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          stateNext = CHECK;
`else
          stateNext = RUN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) stateNext = (inData == sum) ? RUN : ERROR;
      end
`endif
      default: ;
    endcase
    if (reload) stateNext = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rstSeen <= 1'b0;
      count   <= 9'd0;
      loadLen <= 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum     <= 8'd0;
`endif
    end else begin
      rstSeen <= 1'b1;
      if (reload) begin
        count <= 9'd0;
      end else if (accept) begin
        case (state)
          IDLE: begin
            // A length byte of zero encodes a full 256-byte image.
            loadLen <= (inData == 8'd0) ? 9'd256 : {1'b0, inData};
            count   <= 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum     <= 8'd0;
`endif
          end
          LOAD: begin
            count <= countNext;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum   <= sum + inData;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // The store has no reset: images survive rst and reload.
  always_ff @(posedge clk) begin
    if (accept && (state == LOAD)) mem[count[7:0]] <= inData;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; covers either build of IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic       reload;
  logic [7:0] instAddress;
  logic [7:0] instruction;
  logic       cpuRst;
  logic       loadDone;
  logic       loadError;
  logic [8:0] loadCount;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady),
    .reload(reload), .instAddress(instAddress), .instruction(instruction),
    .cpuRst(cpuRst), .loadDone(loadDone), .loadError(loadError), .loadCount(loadCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: optional idle gap with garbage data, then one byte with a bounded wait for inReady
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      inValid = 1'b0;
      inData  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    inData  = b;
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) check("send_timeout", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inData  = 8'hE7;
  endtask

  task automatic check_mem(input string tag, input logic [7:0] a, input logic [7:0] e);
    @(negedge clk);
    instAddress = a;
    #1;
    check(tag, 32'(instruction), 32'(e));
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    #1;
    check("reload_blocks_ready", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] stall_bytes [5];
    stall_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    rst = 1'b0; inData = 8'h00; inValid = 1'b0; reload = 1'b0; instAddress = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inReady", 32'(inReady), 32'd0);
    check("rst_cpuRst", 32'(cpuRst), 32'd0);
    check("rst_loadDone", 32'(loadDone), 32'd0);
    check("rst_loadError", 32'(loadError), 32'd0);
    check("rst_loadCount", 32'(loadCount), 32'd0);
    rst = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(inReady), 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", 32'(inReady), 32'd1);

    // short image 03: 11 22 33
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check("short_count2", 32'(loadCount), 32'd2);
    check("short_cpuRst_mid", 32'(cpuRst), 32'd0);
    send_byte(8'h33, 0);
    check("short_count3", 32'(loadCount), 32'd3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("short_hold_before_chk", 32'(cpuRst), 32'd0);
    check("short_ready_chk", 32'(inReady), 32'd1);
    send_byte(8'h66, 0);
`endif
    check("short_cpuRst", 32'(cpuRst), 32'd1);
    check("short_loadDone", 32'(loadDone), 32'd1);
    check("short_inReady", 32'(inReady), 32'd0);
    check_mem("short_mem0", 8'h00, 8'h11);
    check_mem("short_mem1", 8'h01, 8'h22);
    check_mem("short_mem2", 8'h02, 8'h33);

    // RUN refuses further bytes
    @(negedge clk);
    inValid = 1'b1; inData = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("run_no_ready", 32'(inReady), 32'd0);
    check("run_count_hold", 32'(loadCount), 32'd3);
    inValid = 1'b0;
    check_mem("run_mem0_hold", 8'h00, 8'h11);

    pulse_reload();
    @(negedge clk);
    check("reload_cpuRst", 32'(cpuRst), 32'd0);
    check("reload_ready", 32'(inReady), 32'd1);
    check("reload_count", 32'(loadCount), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // bad checksum: 01+02=03, send 04
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h04, 0);
    @(negedge clk);
    check("bad_loadError", 32'(loadError), 32'd1);
    check("bad_cpuRst", 32'(cpuRst), 32'd0);
    check("bad_inReady", 32'(inReady), 32'd0);
    pulse_reload();
    @(negedge clk);
    check("bad_reload_err", 32'(loadError), 32'd0);
    check("bad_reload_ready", 32'(inReady), 32'd1);
    check_mem("bad_mem2_untouched", 8'h02, 8'h33);
`else
    // 02: AA BB, no checksum stage
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    check("nochk_cpuRst", 32'(cpuRst), 32'd1);
    check("nochk_ready", 32'(inReady), 32'd0);
    check("nochk_loadError", 32'(loadError), 32'd0);
    @(negedge clk);
    inValid = 1'b1; inData = 8'h5C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    check("nochk_extra_count", 32'(loadCount), 32'd2);
    check_mem("nochk_mem0", 8'h00, 8'hAA);
    check_mem("nochk_mem1", 8'h01, 8'hBB);
    check_mem("nochk_mem2_untouched", 8'h02, 8'h33);
    pulse_reload();
`endif

    // full 256-byte image, sum of 00..FF is 0x80 mod 256
    send_byte(8'h00, 0);
    for (int i = 0; i < 255; i++) send_byte(8'(i), 0);
    check("full_count255", 32'(loadCount), 32'd255);
    check("full_cpuRst_mid", 32'(cpuRst), 32'd0);
    send_byte(8'hFF, 0);
    check("full_count256", 32'(loadCount), 32'd256);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h80, 0);
`endif
    check("full_run", 32'(loadDone), 32'd1);
    check_mem("full_memFF", 8'hFF, 8'hFF);
    check_mem("full_mem80", 8'h80, 8'h80);
    pulse_reload();

    // handshake stalls, sum A1..E5 = 0xCF
    send_byte(8'h05, $urandom_range(0, 3));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(stall_bytes[i]);
      send_byte(stall_bytes[i], $urandom_range(0, 4));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hCF, $urandom_range(0, 3));
`endif
    check("stall_count", 32'(loadCount), 32'd5);
    check("stall_run", 32'(cpuRst), 32'd1);
    for (int i = 0; i < 5; i++) begin
      b = exp_q.pop_front();
      check_mem("stall_mem", 8'(i), b);
    end
    check_mem("stall_mem5_untouched", 8'h05, 8'h05);
    pulse_reload();

    // reload colliding with a byte during LOAD
    send_byte(8'h04, 0);
    send_byte(8'h71, 0);
    send_byte(8'h72, 0);
    check("coll_count_before", 32'(loadCount), 32'd2);
    @(negedge clk);
    reload = 1'b1; inValid = 1'b1; inData = 8'hEE;
    @(posedge clk);
    #1;
    reload = 1'b0; inValid = 1'b0;
    @(negedge clk);
    check("coll_count", 32'(loadCount), 32'd0);
    check("coll_idle_ready", 32'(inReady), 32'd1);
    check("coll_cpuRst", 32'(cpuRst), 32'd0);
    check_mem("coll_mem2", 8'h02, 8'hC3);
    check_mem("coll_mem1", 8'h01, 8'h72);

    // mid-load reset keeps partial image
    send_byte(8'h03, 0);
    send_byte(8'h61, 0);
    check("mid_count1", 32'(loadCount), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(inReady), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_count0", 32'(loadCount), 32'd0);
    check("mid_cpuRst", 32'(cpuRst), 32'd0);
    check("mid_ready_first", 32'(inReady), 32'd0);
    check_mem("mid_mem0", 8'h00, 8'h61);
    check_mem("mid_mem1", 8'h01, 8'h72);
    @(negedge clk);
    check("mid_ready_again", 32'(inReady), 32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h5A, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h5A, 0);
`endif
    check("mid_reload_run", 32'(cpuRst), 32'd1);
    check_mem("mid_new_mem0", 8'h00, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory and boot loader for the 8-bit CPU. The block owns the 256×8 instruction store and serves it combinationally on the CPU's instruction-fetch port. After reset it holds the CPU in reset and fills the store from an external byte stream using a valid/ready handshake. It releases the CPU only once a complete image, and optionally a verified checksum, has arrived.

## Interface
Parameters:
- none; the address width is fixed at 8 and the store depth at 256.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset; synchronous, active-low (sampled on rising clk)
- inData  input  8  loader stream byte
- inValid  input  1  inData is valid this cycle
- inReady  output  1  block accepts a byte this cycle
- reload  input  1  abort or finish the current session and return to IDLE
- instAddress  input  8  CPU fetch address
- instruction  output  8  CPU fetch data
- cpuRst  output  1  CPU reset, active-low; high only in RUN
- loadDone  output  1  high in RUN
- loadError  output  1  high in ERROR
- loadCount  output  9  number of image bytes written in the current session

## Operation
- A byte is accepted on a rising edge when inValid && inReady && rst && !reload.
- States: IDLE, LOAD, CHECK, RUN, ERROR. After reset the state is IDLE.
- **IDLE:** inReady=1. The accepted byte is the length L.
  - L=0 means 256.
  - Latch the length into a 9-bit register, clear loadCount and the running sum, go to LOAD.
- **LOAD:** inReady=1. Each accepted byte is handled as follows:
  - Write it to mem[loadCount[7:0]].
  - sum ← sum + byte (mod 256).
  - loadCount ← loadCount + 1.
  - When the incremented count equals the latched length, go to CHECK if checksum is enabled, otherwise go to RUN.
- **CHECK:** inReady=1. The accepted byte is compared against sum.
  - Equal: go to RUN.
  - Different: go to ERROR.
- **RUN:** inReady=0, cpuRst=1, loadDone=1. The store is read-only.
- **ERROR:** inReady=0, loadError=1, cpuRst=0.
- **reload:** in any state, reload=1 at an edge forces IDLE and clears loadCount.
  - reload has priority over a simultaneous byte, which is not accepted because inReady is forced to 0 while reload=1.
- **Fetch:** instruction = mem[instAddress], combinational in all states.
  - The store is never cleared by rst or reload; bytes not overwritten keep their previous image contents.
- Bytes at addresses ≥ L are untouched.
- Upper loadCount bit: loadCount reaches 256 only when L=0.

## Timing
- While rst=0: the state is forced to IDLE at the edge, loadCount=0, sum=0, inReady=0, cpuRst=0, loadDone=0, loadError=0.
- After rst is deasserted, inReady=1 starting in the first cycle following the first edge sampled with rst=1.
- inReady, cpuRst, loadDone and loadError are decoded from the state register only; they never depend combinationally on inValid.
- A write at edge k is visible on instruction from cycle k+1 onward (no read-during-write bypass).
- Release latency: the final image byte (or checksum byte) accepted at edge k puts the block in RUN, so cpuRst=1 from cycle k+1.
- reload=1 at edge k in RUN gives cpuRst=0 from cycle k+1.
- The minimum session is L+2 accepted bytes with checksum enabled, or L+1 without.
- Stalls are unlimited. inValid may drop between bytes, and the state holds with no timeout.
- Mid-session rst=0: the same as a power-on reset. The partial image remains in the store.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- **Defined:** the CHECK state exists. The byte after the image must equal the 8-bit sum of the image bytes. A mismatch enters ERROR, which is left only via reload or rst.
- **Undefined:** there is no CHECK state and no sum register. LOAD goes directly to RUN after L bytes. ERROR is unreachable and loadError is tied to 0.

## Test plan
- **Reset then short image** (checksum enabled):
  - Stimulus: stream 03, 11, 22, 33, checksum 66.
  - Required: mem[0..2]=11,22,33; loadCount=3; cpuRst rises the cycle after 66 is accepted; instAddress=1 gives instruction=22.
- **Bad checksum:**
  - Stimulus: stream 02, 01, 02, then 04.
  - Required: loadError=1, cpuRst stays 0, inReady=0.
  - Then reload=1 for one cycle: IDLE, loadError=0, inReady=1.
- **Full image:**
  - Stimulus: stream 00 (L=256), bytes 00..FF, checksum 80.
  - Required: loadCount=256, mem[FF]=FF, RUN reached.
- **Handshake stalls:**
  - Stimulus: toggle inValid randomly during a 5-byte load, holding inData with garbage while inValid=0.
  - Required: only valid bytes are written; the final contents match the ideal stream.
- **Reload collision and mid-load reset:**
  - Stimulus: reload=1 with inValid=1 at the same edge during LOAD.
  - Required: the byte is not written and loadCount=0.
  - Stimulus: rst=0 for one cycle during LOAD.
  - Required: IDLE, cpuRst=0, previous partial bytes still readable.
- **Checksum compiled out:**
  - Stimulus: without IMEM_LOADER_CHECKSUM_EN, stream 02, AA, BB.
  - Required: RUN is entered after BB; a subsequent extra byte is not accepted (inReady=0); loadError is constant 0.
